// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle for des_key_schedule.
// The decrypt select exists only when KS_DECRYPT_EN is defined.
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
`ifdef KS_DECRYPT_EN
  logic        decrypt;
`endif
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        last;

  modport master (
`ifdef KS_DECRYPT_EN
    output decrypt,
`endif
    output key_valid, key_in, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, last
  );

  modport slave (
`ifdef KS_DECRYPT_EN
    input  decrypt,
`endif
    input  key_valid, key_in, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, last
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on key load, then sixteen PC-2 subkeys (K16..K1 order needs KS_DECRYPT_EN).
// Latency: first subkey valid the cycle after key accept, then one subkey per cycle.
// Backpressure: subkey_ready low holds C, D, round_idx and subkey; key_ready is high only in IDLE.
module des_key_schedule (
  input  logic              clk,
  input  logic              rst_n,
  des_key_schedule_if.slave ks
);
  typedef enum logic {IDLE, RUN} state_t;

  // DES bit numbers, 1 = MSB
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,
                               1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27,
                              19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,
                               7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29,
                              21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,
                               3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8,
                              16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55,
                              30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53,
                              46, 42, 50, 36, 29, 32};

  state_t      state_q, state_nxt;
  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  idx_q, idx_nxt;
  logic [55:0] cd_ld;
  logic [55:0] cd_q;
  logic [47:0] sk;
  logic        unused_parity;
`ifdef KS_DECRYPT_EN
  logic        mode_q, mode_nxt;
`endif

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic two_shift(input logic [4:0] rnd);
    return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

`ifdef KS_DECRYPT_EN
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
`endif

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam logic [5:0] SRC = 6'(64 - PC1[i]);
    assign cd_ld[55-i] = ks.key_in[SRC];
  end

  assign cd_q = {c_q, d_q};

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    localparam logic [5:0] SRC = 6'(56 - PC2[i]);
    assign sk[47-i] = cd_q[SRC];
  end

  assign unused_parity = ^{ks.key_in[56], ks.key_in[48], ks.key_in[40], ks.key_in[32],
                           ks.key_in[24], ks.key_in[16], ks.key_in[8],  ks.key_in[0]};

  assign ks.subkey    = sk;
  assign ks.round_idx = idx_q;
  assign ks.last      = ks.subkey_valid && (idx_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
`ifdef KS_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
      idx_q   <= idx_nxt;
`ifdef KS_DECRYPT_EN
      mode_q  <= mode_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state_q;
    c_nxt           = c_q;
    d_nxt           = d_q;
    idx_nxt         = idx_q;
`ifdef KS_DECRYPT_EN
    mode_nxt        = mode_q;
`endif
    ks.key_ready    = 1'b0;
    ks.subkey_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ks.key_ready = 1'b1;
        if (ks.key_valid) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          c_nxt     = rotl(cd_ld[55:28], 1'b0);
          d_nxt     = rotl(cd_ld[27:0], 1'b0);
`ifdef KS_DECRYPT_EN
          mode_nxt  = ks.decrypt;
          // C16D16 equals C0D0 since the shifts sum to a full 28-bit turn
          if (ks.decrypt) begin
            c_nxt = cd_ld[55:28];
            d_nxt = cd_ld[27:0];
          end
`endif
        end
      end
      RUN: begin
        ks.subkey_valid = 1'b1;
        if (ks.subkey_ready) begin
          if (idx_q == 4'd15) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + 4'd1;
            c_nxt   = rotl(c_q, two_shift({1'b0, idx_q} + 5'd2));
            d_nxt   = rotl(d_q, two_shift({1'b0, idx_q} + 5'd2));
`ifdef KS_DECRYPT_EN
            if (mode_q) begin
              c_nxt = rotr(c_q, two_shift(5'd16 - {1'b0, idx_q}));
              d_nxt = rotr(d_q, two_shift(5'd16 - {1'b0, idx_q}));
            end
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule against a from-scratch DES key schedule model.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_schedule_if ks_if();
  des_key_schedule dut (.clk(clk), .rst_n(rst_n), .ks(ks_if));

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEYP = 64'h123556789ABDDEF0;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Subkey Kn straight from the standard: PC-1, total rotation of rounds 1..n, PC-2.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
    logic [27:0] c = '0;
    logic [27:0] d = '0;
    logic [55:0] cd;
    logic [47:0] k = '0;
    int s = 0;
    for (int j = 0; j < n; j++) s += SH[4'(j)];
    s = s % 28;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = key[6'(64 - PC1[6'(i)])];
      d[5'(27 - i)] = key[6'(64 - PC1[6'(28 + i)])];
    end
    c = (c << s) | (c >> (28 - s));
    d = (d << s) | (d >> (28 - s));
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2[6'(i)])];
    return k;
  endfunction

  logic [47:0] exp_q[$];
  logic [47:0] got[$];
  logic [47:0] enc_ref[$];
  int          vcycles = 0;
  bit          stall_prev = 0;
  logic [47:0] stall_sk = '0;

  // Scoreboard: every cycle out of reset, the outputs must follow the pending expected list.
  always @(negedge clk) begin
    logic dec_s;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      chk("key_ready_vs_valid", ks_if.key_ready, !ks_if.subkey_valid);
      chk("valid_vs_pending", ks_if.subkey_valid, exp_q.size() != 0);
      if (ks_if.subkey_valid && exp_q.size() != 0) begin
        vcycles++;
        chk("subkey", ks_if.subkey, exp_q[0]);
        chk("round_idx", ks_if.round_idx, 16 - exp_q.size());
        chk("last", ks_if.last, exp_q.size() == 1);
        if (stall_prev) chk("stall_hold", ks_if.subkey, stall_sk);
        if (ks_if.subkey_ready) begin
          got.push_back(ks_if.subkey);
          void'(exp_q.pop_front());
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_sk = ks_if.subkey;
        end
      end else begin
        chk("last_when_idle", ks_if.last, 1'b0);
      end
      if (ks_if.key_valid && ks_if.key_ready) begin
`ifdef KS_DECRYPT_EN
        dec_s = ks_if.decrypt;
`else
        dec_s = 1'b0;
`endif
        for (int n = 0; n < 16; n++)
          exp_q.push_back(model_k(ks_if.key_in, dec_s ? 16 - n : n + 1));
        got.delete();
        vcycles = 0;
      end
    end
  end

  task automatic load(input logic [63:0] key, input logic dec);
    bit ok = 0;
    @(posedge clk); #1;
    ks_if.key_valid = 1'b1;
    ks_if.key_in = key;
    ks_if.subkey_ready = 1'b1;
`ifdef KS_DECRYPT_EN
    ks_if.decrypt = dec;
`else
    if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ks_if.key_ready;
    end
    chk("load_accepted", ok, 1'b1);
    @(posedge clk); #1;
    ks_if.key_valid = 1'b0;
    ks_if.key_in = {$urandom, $urandom};
  endtask

  // rnd=1 toggles subkey_ready randomly; busy_at>=0 pulses a foreign key during the run.
  task automatic drain(input bit rnd, input int busy_at);
    bit done = 0;
    bit fire = 0;
    bit fired = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      ks_if.key_valid = 1'b0;
      ks_if.subkey_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
`ifdef KS_DECRYPT_EN
      ks_if.decrypt = 1'($urandom_range(0, 1));
`endif
      if (fire) begin
        ks_if.key_valid = 1'b1;
        ks_if.key_in = 64'h0123456789ABCDEF;
        fire = 0;
      end
      @(negedge clk);
      if (!fired && busy_at >= 0 && ks_if.subkey_valid && ks_if.round_idx == 4'(busy_at)) begin
        fire = 1;
        fired = 1;
      end
      done = !ks_if.subkey_valid;
    end
    ks_if.key_valid = 1'b0;
    chk("drain_done", done, 1'b1);
  endtask

  function automatic int seq_diff();
    int bad = 0;
    if (got.size() != enc_ref.size()) bad++;
    for (int i = 0; i < 16; i++)
      if (i < got.size() && i < enc_ref.size() && got[i] !== enc_ref[i]) bad++;
    return bad;
  endfunction

  initial begin
    bit hit;
    ks_if.key_valid = 1'b0;
    ks_if.key_in = '0;
    ks_if.subkey_ready = 1'b0;
`ifdef KS_DECRYPT_EN
    ks_if.decrypt = 1'b0;
`endif
    #12;
    chk("rst_key_ready", ks_if.key_ready, 1'b1);
    chk("rst_subkey_valid", ks_if.subkey_valid, 1'b0);
    chk("rst_round_idx", ks_if.round_idx, 4'd0);
    chk("rst_last", ks_if.last, 1'b0);
    chk("rst_subkey", ks_if.subkey, 48'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    chk("model_k1", model_k(KEY, 1), 48'h1B02EFFC7072);
    chk("model_k2", model_k(KEY, 2), 48'h79AED9DBC9E5);
    chk("model_k16", model_k(KEY, 16), 48'hCB3D8B0E17F5);

    // full-rate encrypt vector
    load(KEY, 1'b0);
    drain(1'b0, -1);
    chk("enc_count", got.size(), 16);
    chk("enc_valid_cycles", vcycles, 16);
    if (got.size() == 16) begin
      chk("enc_k1", got[0], 48'h1B02EFFC7072);
      chk("enc_k2", got[1], 48'h79AED9DBC9E5);
      chk("enc_k16", got[15], 48'hCB3D8B0E17F5);
    end
    enc_ref = got;

    // backpressure
    load(KEY, 1'b0);
    drain(1'b1, -1);
    chk("bp_sequence", seq_diff(), 0);

    // foreign key while busy
    load(KEY, 1'b0);
    drain(1'b1, 5);
    chk("busy_sequence", seq_diff(), 0);

    // reset mid-run
    load(KEY, 1'b0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = ks_if.subkey_valid && ks_if.round_idx == 4'd7;
    end
    chk("reach_idx7", hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_subkey_valid", ks_if.subkey_valid, 1'b0);
    chk("abort_key_ready", ks_if.key_ready, 1'b1);
    chk("abort_round_idx", ks_if.round_idx, 4'd0);
    chk("abort_last", ks_if.last, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    load(KEY, 1'b0);
    drain(1'b0, -1);
    chk("post_rst_count", got.size(), 16);
    if (got.size() != 0) chk("post_rst_k1", got[0], 48'h1B02EFFC7072);

    // parity bits ignored
    load(KEYP, 1'b0);
    drain(1'b1, -1);
    chk("parity_sequence", seq_diff(), 0);

`ifdef KS_DECRYPT_EN
    load(KEY, 1'b1);
    drain(1'b0, -1);
    chk("dec_count", got.size(), 16);
    if (got.size() == 16) begin
      chk("dec_idx0", got[0], 48'hCB3D8B0E17F5);
      chk("dec_idx14", got[14], 48'h79AED9DBC9E5);
      chk("dec_idx15", got[15], 48'h1B02EFFC7072);
    end
`endif

    // random keys, modes, gaps and ready patterns
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      load({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      drain(1'b1, (r % 2 == 0) ? int'($urandom_range(0, 15)) : -1);
      chk("rand_count", got.size(), 16);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
